// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data, loader and memory-macro signals around the shared
// memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  // Handshake: a requester raises *_req with stable address/data and holds them
  // until the matching *_gnt is high in the same cycle. The grant cycle is the
  // transfer cycle. Read data returns later as a one-cycle *_rvalid pulse. A
  // request dropped before its grant is simply never served.
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_be;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;

  logic          cpu_hold;
  logic          if_stall;
  logic          dm_stall;

  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           ld_req, ld_addr, ld_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, ld_gnt,
           cpu_hold, if_stall, dm_stall,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           ld_req, ld_addr, ld_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, ld_gnt,
           cpu_hold, if_stall, dm_stall,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch, data-memory and loader,
// sequencing reads against the macro's fixed read latency.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4,
  localparam int SW        = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              dbg_state,
  output logic [2:0]        dbg_lat_cnt,
  output logic [SW-1:0]     dbg_starve_cnt
);

  typedef enum logic {S_IDLE, S_RBUSY} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [2:0]    lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;
  logic          starve_win;
  logic          busy_if, busy_dm;

  // Fetch overrides data only once data has won STARVE_MAX times in a row.
  assign starve_win = bus.if_req && (starve_q == SW'(STARVE_MAX));
  assign busy_if    = (state_q == S_RBUSY) && (owner_q == OWN_IF);
  assign busy_dm    = (state_q == S_RBUSY) && (owner_q == OWN_DM);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    lat_d         = lat_q;
    starve_d      = starve_q;
    gnt_addr      = '0;
    gnt_wdata     = '0;
    bus.if_gnt    = 1'b0;
    bus.dm_gnt    = 1'b0;
    bus.ld_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.dm_rvalid = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.if_rdata  = if_rdata_q;
    bus.dm_rdata  = dm_rdata_q;

    case (state_q)
      S_IDLE: begin
        // Grants are gated by reset so every output is quiet while held in reset.
        if (reset) begin
          if (bus.ld_req) begin
            bus.ld_gnt = 1'b1;
            bus.mem_en = 1'b1;
            bus.mem_we = 1'b1;
            bus.mem_be = 4'hF;
            gnt_addr   = bus.ld_addr;
            gnt_wdata  = bus.ld_wdata;
          end else if (bus.dm_req && !starve_win) begin
            bus.dm_gnt = 1'b1;
            bus.mem_en = 1'b1;
            bus.mem_we = bus.dm_we;
            gnt_addr   = bus.dm_addr;
            if (bus.dm_we) begin
              bus.mem_be = bus.dm_be;
              gnt_wdata  = bus.dm_wdata;
            end else begin
              bus.mem_be = 4'hF;
              state_d    = S_RBUSY;
              lat_d      = 3'd1;
              owner_d    = OWN_DM;
            end
          end else if (bus.if_req) begin
            bus.if_gnt = 1'b1;
            bus.mem_en = 1'b1;
            bus.mem_be = 4'hF;
            gnt_addr   = bus.if_addr;
            state_d    = S_RBUSY;
            lat_d      = 3'd1;
            owner_d    = OWN_IF;
          end
        end
      end
      S_RBUSY: begin
        if (lat_q == 3'(RD_LAT)) begin
          if (owner_q == OWN_IF) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_rdata;
          end else begin
            bus.dm_rvalid = 1'b1;
            bus.dm_rdata  = bus.mem_rdata;
          end
          state_d = S_IDLE;
          lat_d   = 3'd0;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
    endcase

    if (!bus.if_req || bus.if_gnt) begin
      starve_d = '0;
    end else if (bus.dm_gnt && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end

    bus.mem_addr  = gnt_addr;
    bus.mem_wdata = gnt_wdata;
    bus.cpu_hold  = reset && bus.ld_req;
    bus.if_stall  = reset && (bus.if_req || busy_if) && !bus.if_rvalid;
    // A data write is done in its grant cycle; a data read only at its rvalid.
    bus.dm_stall  = reset && ((bus.dm_req && !(bus.dm_gnt && bus.dm_we)) || busy_dm)
                    && !bus.dm_rvalid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      lat_q      <= 3'd0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      if (bus.if_rvalid) if_rdata_q <= bus.mem_rdata;
      if (bus.dm_rvalid) dm_rdata_q <= bus.mem_rdata;
    end
  end

  assign dbg_state      = state_q;
  assign dbg_lat_cnt    = lat_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grant/rvalid events are queued
// with their cycle numbers and a negedge monitor checks every DUT event.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD_LAT = 2;
  localparam int STARVE_MAX = 4;
  localparam int EW = 90;
  localparam logic [3:0] T_LD = 4'd1, T_DM = 4'd2, T_IF = 4'd3, T_IRV = 4'd4, T_DRV = 4'd5;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic dbg_state;
  logic [2:0] dbg_lat_cnt;
  logic [2:0] dbg_starve_cnt;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_lat_cnt    (dbg_lat_cnt),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // memory macro model, read data valid RD_LAT(=2) cycles after the read strobe
  logic [31:0] mem [0:255];
  logic [31:0] rd_p0 = 32'h0;
  logic [31:0] rd_p1 = 32'h0;
  logic mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'h2008_0001;
      mem[5]  <= 32'h1357_9BDF;
      mem[6]  <= 32'h600D_F00D;
      mem[16] <= 32'hAABB_CCDD;
      mem_ready <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    if (bus.mem_en && !bus.mem_we) rd_p0 <= mem[bus.mem_addr[9:2]];
    rd_p1 <= rd_p0;
  end
  assign bus.mem_rdata = rd_p1;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [EW-1:0] mk(int c, logic [3:0] tag, logic en, logic we,
                                       logic [3:0] be, logic [31:0] a, logic [31:0] d);
    return {c[15:0], tag, en, we, be, a, d};
  endfunction

  always @(negedge clk) begin : monitor
    int n;
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    n = int'(bus.if_gnt) + int'(bus.dm_gnt) + int'(bus.ld_gnt)
      + int'(bus.if_rvalid) + int'(bus.dm_rvalid);
    if (n > 1) begin
      checks++;
      errors++;
      $display("FAIL onehot cyc=%0d events=%0d required<=1", cyc, n);
    end else if (n == 1) begin
      if (bus.ld_gnt || bus.dm_gnt || bus.if_gnt)
        act = mk(cyc, bus.ld_gnt ? T_LD : (bus.dm_gnt ? T_DM : T_IF), bus.mem_en, bus.mem_we,
                 bus.mem_be, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 32'h0);
      else
        act = mk(cyc, bus.if_rvalid ? T_IRV : T_DRV, 1'b0, 1'b0, 4'h0,
                 bus.if_rvalid ? bus.if_rdata : bus.dm_rdata, 32'h0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event act=%h required=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL event act=%h required=%h", act, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_reqs();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    bus.ld_req = 1'b0;
  endtask

  int c0;

  initial begin
    reset        = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h10;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h200;
    bus.dm_wdata = 32'h0;
    bus.dm_be    = 4'hF;
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 32'h100;
    bus.ld_wdata = 32'h0BAD_0001;

    // reset with every request high: all outputs quiet
    repeat (3) @(posedge clk);
    at_neg();
    chk("reset_ctrl", {22'b0, bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid, bus.ld_gnt,
                       bus.cpu_hold, bus.if_stall, bus.dm_stall, bus.mem_en, bus.mem_we}, 32'h0);
    chk("reset_be", {28'b0, bus.mem_be}, 32'h0);
    chk("reset_addr", bus.mem_addr, 32'h0);
    chk("reset_wdata", bus.mem_wdata, 32'h0);
    chk("reset_if_rdata", bus.if_rdata, 32'h0);
    chk("reset_dm_rdata", bus.dm_rdata, 32'h0);
    chk("reset_regs", {26'b0, dbg_state, dbg_lat_cnt, dbg_starve_cnt[1:0]}, 32'h0);

    // release: loader wins in the very first cycle
    tick();
    reset = 1'b1;
    c0 = cyc;
    exp_q.push_back(mk(c0, T_LD, 1'b1, 1'b1, 4'hF, 32'h100, 32'h0BAD_0001));
    at_neg();
    chk("cpu_hold_release", {31'b0, bus.cpu_hold}, 32'd1);
    tick();
    idle_reqs();
    tick();
    tick();

    // single fetch read
    c0 = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    exp_q.push_back(mk(c0, T_IF, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0));
    exp_q.push_back(mk(c0 + 2, T_IRV, 1'b0, 1'b0, 4'h0, 32'h2008_0001, 32'h0));
    at_neg();
    chk("if_stall_c0", {31'b0, bus.if_stall}, 32'd1);
    tick();
    bus.if_req = 1'b0;
    at_neg();
    chk("if_stall_c1", {31'b0, bus.if_stall}, 32'd1);
    chk("lat_cnt_c1", {29'b0, dbg_lat_cnt}, 32'd1);
    tick();
    at_neg();
    chk("if_stall_c2", {31'b0, bus.if_stall}, 32'd0);
    tick();
    at_neg();
    chk("if_rdata_hold", bus.if_rdata, 32'h2008_0001);
    tick();

    // collision: data write beats fetch, fetch follows next cycle
    c0 = cyc;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h40;
    bus.dm_wdata = 32'h203;
    bus.dm_be    = 4'b0011;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h14;
    exp_q.push_back(mk(c0, T_DM, 1'b1, 1'b1, 4'b0011, 32'h40, 32'h203));
    exp_q.push_back(mk(c0 + 1, T_IF, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0));
    exp_q.push_back(mk(c0 + 3, T_IRV, 1'b0, 1'b0, 4'h0, 32'h1357_9BDF, 32'h0));
    at_neg();
    chk("dm_stall_wr_gnt", {31'b0, bus.dm_stall}, 32'd0);
    chk("if_stall_waiting", {31'b0, bus.if_stall}, 32'd1);
    tick();
    bus.dm_req = 1'b0;
    tick();
    bus.if_req = 1'b0;
    tick();
    tick();

    // starvation: four data writes, then fetch forces its way in
    c0 = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h18;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b1;
    bus.dm_be   = 4'hF;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(c0 + k, T_DM, 1'b1, 1'b1, 4'hF, 32'h80 + 32'(4 * k), 32'hD0 + 32'(k)));
    exp_q.push_back(mk(c0 + 4, T_IF, 1'b1, 1'b0, 4'hF, 32'h18, 32'h0));
    exp_q.push_back(mk(c0 + 6, T_IRV, 1'b0, 1'b0, 4'h0, 32'h600D_F00D, 32'h0));
    exp_q.push_back(mk(c0 + 7, T_DM, 1'b1, 1'b1, 4'hF, 32'h90, 32'hD4));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      bus.dm_addr  = 32'h80 + 32'(4 * k);
      bus.dm_wdata = 32'hD0 + 32'(k);
      at_neg();
      chk("starve_cnt_ramp", {29'b0, dbg_starve_cnt}, 32'(k));
    end
    tick();
    bus.dm_addr  = 32'h90;
    bus.dm_wdata = 32'hD4;
    at_neg();
    chk("starve_cnt_max", {29'b0, dbg_starve_cnt}, 32'd4);
    tick();
    bus.if_addr = 32'h1C;
    at_neg();
    chk("starve_cnt_clear", {29'b0, dbg_starve_cnt}, 32'd0);
    chk("dm_stall_rbusy", {31'b0, bus.dm_stall}, 32'd1);
    tick();
    bus.if_req = 1'b0;
    tick();
    at_neg();
    chk("dm_stall_late_gnt", {31'b0, bus.dm_stall}, 32'd0);
    tick();
    bus.dm_req = 1'b0;
    tick();

    // loader preemption, then data write, then fetch reads loader word
    c0 = cyc;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h8;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'hC0;
    bus.dm_wdata = 32'h55;
    bus.dm_be    = 4'hF;
    bus.ld_req   = 1'b1;
    for (int k = 0; k < 3; k++)
      exp_q.push_back(mk(c0 + k, T_LD, 1'b1, 1'b1, 4'hF, 32'(4 * k), 32'hA0 + 32'(k)));
    exp_q.push_back(mk(c0 + 3, T_DM, 1'b1, 1'b1, 4'hF, 32'hC0, 32'h55));
    exp_q.push_back(mk(c0 + 4, T_IF, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0));
    exp_q.push_back(mk(c0 + 6, T_IRV, 1'b0, 1'b0, 4'h0, 32'hA2, 32'h0));
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      bus.ld_addr  = 32'(4 * k);
      bus.ld_wdata = 32'hA0 + 32'(k);
      at_neg();
      chk("cpu_hold_ld", {31'b0, bus.cpu_hold}, 32'd1);
      chk("dm_stall_ld", {31'b0, bus.dm_stall}, 32'd1);
    end
    tick();
    bus.ld_req = 1'b0;
    at_neg();
    chk("cpu_hold_end", {31'b0, bus.cpu_hold}, 32'd0);
    chk("dm_stall_after_ld", {31'b0, bus.dm_stall}, 32'd0);
    tick();
    bus.dm_req = 1'b0;
    tick();
    bus.if_req = 1'b0;
    tick();
    tick();

    // reset in the middle of a data read: the read is discarded
    c0 = cyc;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h40;
    exp_q.push_back(mk(c0, T_DM, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0));
    at_neg();
    chk("dm_stall_rd_gnt", {31'b0, bus.dm_stall}, 32'd1);
    tick();
    bus.dm_req = 1'b0;
    reset = 1'b0;
    at_neg();
    chk("state_in_reset", {31'b0, dbg_state}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    at_neg();
    chk("state_after_release", {31'b0, dbg_state}, 32'd0);
    repeat (3) tick();

    // fresh read sees the earlier byte-enabled write
    c0 = cyc;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h40;
    exp_q.push_back(mk(c0, T_DM, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0));
    exp_q.push_back(mk(c0 + 2, T_DRV, 1'b0, 1'b0, 4'h0, 32'hAABB_0203, 32'h0));
    tick();
    bus.dm_req = 1'b0;
    at_neg();
    chk("dm_stall_rd_wait", {31'b0, bus.dm_stall}, 32'd1);
    tick();
    at_neg();
    chk("dm_stall_rvalid", {31'b0, bus.dm_stall}, 32'd0);
    tick();

    // drain with a bounded wait, then report leftovers
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) tick();
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_event act=none required=%h", exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
